// File: rtl/bus_pkg.sv
// Shared definitions for the burst responder: bus field widths, FSM state
// encoding, request payload and the request legality check.
package bus_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_RD_WAIT = 3'd1;
    localparam logic [STATE_W-1:0] ST_RD_DATA = 3'd2;
    localparam logic [STATE_W-1:0] ST_RD_END  = 3'd3;
    localparam logic [STATE_W-1:0] ST_WR_DATA = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERR     = 3'd5;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic               rnw;
        logic [BURST_W-1:0] burst;
    } bus_req_t;

    // True when the burst starts below base, is unaligned, or would run past the last word.
    function automatic logic req_illegal(
        input logic [ADDR_W-1:0]  addr,
        input logic [BURST_W-1:0] burst,
        input logic [ADDR_W-1:0]  base,
        input logic [ADDR_W:0]    depth
    );
        logic [ADDR_W-1:0] offset;
        logic [ADDR_W:0]   last_word;
        offset    = addr - base;
        last_word = (ADDR_W + 1)'(offset >> 2) + (ADDR_W + 1)'(burst);
        return (addr < base) || (addr[1:0] != 2'b00) || (last_word >= depth);
    endfunction

endpackage

// File: rtl/responder_sram.sv
// Single-port word storage with synchronous write and registered read;
// contents are deliberately never reset.
module responder_sram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              enable,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  write_data,
    output logic [WIDTH-1:0]  read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (enable) begin
            if (write_enable) begin
                mem[address] <= write_data;
            end else begin
                read_data <= mem[address];
            end
        end
    end

endmodule

// File: rtl/bus_burst_responder.sv
// Burst slave: serves read and write bursts against a local word store,
// flags illegal requests, and honours master busy/error/end signalling.
module bus_burst_responder
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned       DEPTH_WORDS  = 1024,
    parameter int unsigned       READ_LATENCY = 2,
    parameter int unsigned       BUSY_PERIOD  = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               busIn_begin_transaction,
    input  logic [ADDR_W-1:0]  busIn_address_data,
    input  logic               busIn_read_n_write,
    input  logic [BURST_W-1:0] busIn_burst_size,
    input  logic               busIn_data_valid,
    input  logic               busIn_end_transaction,
    input  logic               busIn_busy,
    input  logic               busIn_error,
    output logic [DATA_W-1:0]  busOut_address_data,
    output logic               busOut_data_valid,
    output logic               busOut_end_transaction,
    output logic               busOut_busy,
    output logic               busOut_error
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = BURST_W + 1;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned ACC_W  = 16;
    localparam logic [WAIT_W-1:0] WAIT_INIT =
        (READ_LATENCY >= 3) ? WAIT_W'(READ_LATENCY - 3) : '0;
    localparam logic [ACC_W-1:0] ACC_LIMIT = ACC_W'(BUSY_PERIOD);

    logic [STATE_W-1:0] state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [WAIT_W-1:0]  wait_cnt, wait_d;
    logic [ACC_W-1:0]   acc_cnt, acc_d;
    logic               dv_q, dv_d;
    logic               end_q, end_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    bus_req_t           req_c;
    logic               req_bad_c;
    logic [IDX_W-1:0]   req_idx_c;

    logic               mem_en_c;
    logic               mem_we_c;
    logic [IDX_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]  mem_wdata_c;
    logic [DATA_W-1:0]  mem_rdata;

    assign req_c     = '{addr: busIn_address_data, rnw: busIn_read_n_write, burst: busIn_burst_size};
    assign req_bad_c = req_illegal(req_c.addr, req_c.burst, BASE_ADDRESS, (ADDR_W + 1)'(DEPTH_WORDS));
    assign req_idx_c = IDX_W'((req_c.addr - BASE_ADDRESS) >> 2);

    responder_sram #(
        .DEPTH  (DEPTH_WORDS),
        .WIDTH  (DATA_W),
        .ADDR_W (IDX_W)
    ) u_sram (
        .clock        (clock),
        .enable       (mem_en_c),
        .write_enable (mem_we_c),
        .address      (mem_addr_c),
        .write_data   (mem_wdata_c),
        .read_data    (mem_rdata)
    );

    // State register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
            acc_cnt  <= '0;
            dv_q     <= 1'b0;
            end_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            cnt      <= cnt_d;
            wait_cnt <= wait_d;
            acc_cnt  <= acc_d;
            dv_q     <= dv_d;
            end_q    <= end_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Next state, counters, memory strobes and next output values.
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        cnt_d       = cnt;
        wait_d      = wait_cnt;
        acc_d       = acc_cnt;
        dv_d        = 1'b0;
        end_d       = 1'b0;
        busy_d      = 1'b0;
        err_d       = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = idx;
        mem_wdata_c = busIn_address_data;

        case (state)
            ST_IDLE: begin
                if (busIn_begin_transaction) begin
                    idx_d  = req_idx_c;
                    cnt_d  = CNT_W'(req_c.burst);
                    wait_d = WAIT_INIT;
                    acc_d  = '0;
                    if (req_bad_c) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (!req_c.rnw) begin
                        state_d = ST_WR_DATA;
                    end else if (READ_LATENCY <= 1) begin
                        // Single-cycle latency: first word is fetched in the begin cycle.
                        mem_en_c   = 1'b1;
                        mem_addr_c = req_idx_c;
                        dv_d       = 1'b1;
                        if (req_c.burst == '0) begin
                            state_d = ST_RD_END;
                        end else begin
                            idx_d   = req_idx_c + IDX_W'(1);
                            cnt_d   = CNT_W'(req_c.burst) - CNT_W'(1);
                            state_d = ST_RD_DATA;
                        end
                    end else if (READ_LATENCY == 2) begin
                        state_d = ST_RD_DATA;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end

            ST_RD_WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = ST_RD_DATA;
                end else begin
                    wait_d = wait_cnt - WAIT_W'(1);
                end
            end

            // A fetch here surfaces as a valid word on the following cycle.
            ST_RD_DATA: begin
                if (!busIn_busy) begin
                    mem_en_c = 1'b1;
                    dv_d     = 1'b1;
                    if (cnt == '0) begin
                        state_d = ST_RD_END;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
            end

            ST_RD_END: begin
                end_d   = 1'b1;
                state_d = ST_IDLE;
            end

            // cnt underflows past zero once the burst is full; its MSB then blocks further stores.
            ST_WR_DATA: begin
                if (busIn_data_valid && !busy_q && !cnt[CNT_W-1]) begin
                    mem_en_c = 1'b1;
                    mem_we_c = 1'b1;
                    idx_d    = idx + IDX_W'(1);
                    cnt_d    = cnt - CNT_W'(1);
                    acc_d    = acc_cnt + ACC_W'(1);
                    if ((BUSY_PERIOD != 0) && (acc_cnt + ACC_W'(1) == ACC_LIMIT)) begin
                        busy_d = 1'b1;
                        acc_d  = '0;
                    end
                end
                if (busIn_end_transaction) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            ST_ERR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Master abort wins over everything outside IDLE.
        if ((state != ST_IDLE) && busIn_error) begin
            state_d  = ST_IDLE;
            dv_d     = 1'b0;
            end_d    = 1'b0;
            busy_d   = 1'b0;
            err_d    = 1'b0;
            mem_en_c = 1'b0;
            mem_we_c = 1'b0;
        end
    end

    // Gating keeps read data at zero whenever no word is valid, including during reset.
    assign busOut_address_data    = dv_q ? mem_rdata : '0;
    assign busOut_data_valid      = dv_q;
    assign busOut_end_transaction = end_q;
    assign busOut_busy            = busy_q;
    assign busOut_error           = err_q;

endmodule

// File: tb/tb_bus_burst_responder.sv
// Self-checking bench for bus_burst_responder: a table of directed bursts plus
// hand-written sequences for busy stalls, aborts, over-long writes and reset.
module tb_bus_burst_responder;

    localparam logic [31:0] BASE     = 32'h0000_1000;
    localparam int          DEPTH    = 1024;
    localparam int          READ_LAT = 2;
    localparam int          BUSY_P   = 4;
    localparam int          NV       = 13;

    typedef struct {
        logic        rnw;
        logic [31:0] addr;
        logic [7:0]  burst;
        logic [31:0] data0;
        logic        exp_err;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        b_begin = 1'b0;
    logic [31:0] b_addr = '0;
    logic        b_rnw = 1'b0;
    logic [7:0]  b_burst = '0;
    logic        b_dv = 1'b0;
    logic        b_end = 1'b0;
    logic        b_busy = 1'b0;
    logic        b_err = 1'b0;
    logic [31:0] o_data;
    logic        o_dv;
    logic        o_end;
    logic        o_busy;
    logic        o_err;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];

    bus_burst_responder #(
        .BASE_ADDRESS (BASE),
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (READ_LAT),
        .BUSY_PERIOD  (BUSY_P)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .busIn_begin_transaction(b_begin),
        .busIn_address_data     (b_addr),
        .busIn_read_n_write     (b_rnw),
        .busIn_burst_size       (b_burst),
        .busIn_data_valid       (b_dv),
        .busIn_end_transaction  (b_end),
        .busIn_busy             (b_busy),
        .busIn_error            (b_err),
        .busOut_address_data    (o_data),
        .busOut_data_valid      (o_dv),
        .busOut_end_transaction (o_end),
        .busOut_busy            (o_busy),
        .busOut_error           (o_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        b_begin = 1'b0; b_addr = '0; b_rnw = 1'b0; b_burst = '0;
        b_dv = 1'b0; b_end = 1'b0; b_busy = 1'b0; b_err = 1'b0;
    endtask

    // Entered just after a negedge; begin is driven in cycle 0, outputs sampled at each later negedge.
    task automatic read_txn(input logic [31:0] addr, input logic [7:0] burst, input logic [31:0] data0,
                            input logic exp_err, input int busy_at, input int busy_len, input string tag);
        int nwords, first, end_cnt, end_cyc, err_cnt, err_cyc, ncyc;
        nwords = 0; first = -1; end_cnt = 0; end_cyc = -1; err_cnt = 0; err_cyc = -1;
        ncyc = READ_LAT + int'(burst) + busy_len + 4;
        b_begin = 1'b1; b_addr = addr; b_rnw = 1'b1; b_burst = burst;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock);
            b_begin = 1'b0; b_addr = '0; b_rnw = 1'b0; b_burst = '0;
            b_busy = (busy_len > 0) && (k >= busy_at) && (k < busy_at + busy_len);
            if (o_dv) begin
                chk({tag, "_data"}, o_data, data0 + 32'(nwords));
                if (first < 0) first = k;
                nwords++;
            end else begin
                chk({tag, "_zero"}, o_data, 32'h0);
            end
            if (o_end) begin end_cnt++; end_cyc = k; end
            if (o_err) begin err_cnt++; err_cyc = k; end
        end
        b_busy = 1'b0;
        if (exp_err) begin
            chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd1);
            chk({tag, "_err_cyc"}, 32'(err_cyc), 32'd1);
            chk({tag, "_nwords"}, 32'(nwords), 32'd0);
            chk({tag, "_end_cnt"}, 32'(end_cnt), 32'd0);
        end else begin
            chk({tag, "_nwords"}, 32'(nwords), 32'(int'(burst) + 1));
            chk({tag, "_first"}, 32'(first), 32'(READ_LAT));
            chk({tag, "_end_cnt"}, 32'(end_cnt), 32'd1);
            chk({tag, "_end_cyc"}, 32'(end_cyc), 32'(READ_LAT + int'(burst) + 1 + busy_len));
            chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        end
    endtask

    // Master write model: presents each word until a cycle with busOut_busy low accepts it.
    task automatic write_txn(input logic [31:0] addr, input logic [7:0] burst, input int nwords,
                             input logic [31:0] data0, input logic end_last, input logic exp_err,
                             input int exp_busy, input string tag);
        int sent, busy_cnt, err_cnt, stray, ncyc;
        logic ended;
        sent = 0; busy_cnt = 0; err_cnt = 0; stray = 0; ended = 1'b0;
        ncyc = 2 * nwords + 6;
        b_begin = 1'b1; b_addr = addr; b_rnw = 1'b0; b_burst = burst;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock);
            b_begin = 1'b0; b_burst = '0;
            if (o_err) err_cnt++;
            if (o_busy) busy_cnt++;
            if (o_dv || o_end) stray++;
            if (sent < nwords) begin
                b_dv   = 1'b1;
                b_addr = data0 + 32'(sent);
                b_end  = end_last && !o_busy && (sent == nwords - 1);
                if (!o_busy) begin
                    sent++;
                    if (b_end) ended = 1'b1;
                end
            end else if (!ended) begin
                b_dv = 1'b0; b_addr = '0; b_end = 1'b1; ended = 1'b1;
            end else begin
                b_dv = 1'b0; b_addr = '0; b_end = 1'b0;
            end
        end
        idle_inputs();
        chk({tag, "_err_cnt"}, 32'(err_cnt), exp_err ? 32'd1 : 32'd0);
        chk({tag, "_busy_cnt"}, 32'(busy_cnt), 32'(exp_busy));
        chk({tag, "_stray"}, 32'(stray), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, BASE + 32'd12,       8'd7, 32'd1,          1'b0};
        vecs[1]  = '{1'b1, BASE + 32'd12,       8'd7, 32'd1,          1'b0};
        vecs[2]  = '{1'b0, BASE + 32'd4064,     8'd7, 32'h100,        1'b0};
        vecs[3]  = '{1'b0, BASE + 32'd4080,     8'd7, 32'hDEAD_0000,  1'b1};
        vecs[4]  = '{1'b0, BASE + 32'd2,        8'd0, 32'h55,         1'b1};
        vecs[5]  = '{1'b0, BASE - 32'd4,        8'd0, 32'h66,         1'b1};
        vecs[6]  = '{1'b1, BASE + 32'd4064,     8'd7, 32'h100,        1'b0};
        vecs[7]  = '{1'b1, BASE + 32'd4092,     8'd0, 32'h107,        1'b0};
        vecs[8]  = '{1'b1, BASE + 32'd4092,     8'd1, 32'h0,          1'b1};
        vecs[9]  = '{1'b0, BASE + 32'd4092,     8'd1, 32'h77,         1'b1};
        vecs[10] = '{1'b0, BASE,                8'd2, 32'hA0,         1'b0};
        vecs[11] = '{1'b1, BASE,                8'd2, 32'hA0,         1'b0};
        vecs[12] = '{1'b1, BASE + 32'd4088,     8'd1, 32'h106,        1'b0};

        // Asynchronous reset clears outputs before any clock edge.
        #1 reset = 1'b1;
        #2;
        chk("rst_dv", 32'(o_dv), 32'd0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_end", 32'(o_end), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rnw)
                read_txn(vecs[i].addr, vecs[i].burst, vecs[i].data0, vecs[i].exp_err, 0, 0,
                         $sformatf("v%0d", i));
            else
                write_txn(vecs[i].addr, vecs[i].burst, int'(vecs[i].burst) + 1, vecs[i].data0, 1'b1,
                          vecs[i].exp_err, vecs[i].exp_err ? 0 : int'(vecs[i].burst) / BUSY_P,
                          $sformatf("v%0d", i));
        end

        // Read stalled by master busy for two cycles.
        read_txn(BASE + 32'd12, 8'd7, 32'd1, 1'b0, 5, 2, "rd_busy");

        // Over-long write: only burst_size+1 words stored, end arrives separately.
        write_txn(BASE + 32'd80, 8'd3, 4, 32'h60, 1'b1, 1'b0, 0, "pre20");
        write_txn(BASE + 32'd80, 8'd1, 4, 32'h50, 1'b0, 1'b0, 0, "long20");
        read_txn(BASE + 32'd80, 8'd1, 32'h50, 1'b0, 0, 0, "rd20");
        read_txn(BASE + 32'd88, 8'd1, 32'h62, 1'b0, 0, 0, "rd22");

        // Early end after two of eight words.
        write_txn(BASE + 32'd120, 8'd7, 2, 32'h90, 1'b1, 1'b0, 0, "early30");
        read_txn(BASE + 32'd120, 8'd1, 32'h90, 1'b0, 0, 0, "rd30");

        // Master abort mid write keeps stored words.
        b_begin = 1'b1; b_addr = BASE + 32'd160; b_rnw = 1'b0; b_burst = 8'd3;
        @(negedge clock);
        b_begin = 1'b0; b_burst = '0; b_dv = 1'b1; b_addr = 32'hC0;
        @(negedge clock);
        b_addr = 32'hC1;
        @(negedge clock);
        b_dv = 1'b0; b_addr = 32'hC2; b_err = 1'b1;
        @(negedge clock);
        idle_inputs();
        chk("wabort_busy", 32'(o_busy), 32'd0);
        chk("wabort_err", 32'(o_err), 32'd0);
        read_txn(BASE + 32'd160, 8'd1, 32'hC0, 1'b0, 0, 0, "rd40");

        // Master abort mid read silences outputs on the next cycle.
        b_begin = 1'b1; b_addr = BASE + 32'd12; b_rnw = 1'b1; b_burst = 8'd7;
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        chk("rabort_w1", o_data, 32'd1);
        @(negedge clock);
        chk("rabort_w2", o_data, 32'd2);
        b_err = 1'b1;
        @(negedge clock);
        b_err = 1'b0;
        chk("rabort_dv", 32'(o_dv), 32'd0);
        chk("rabort_data", o_data, 32'h0);
        chk("rabort_end", 32'(o_end), 32'd0);
        read_txn(BASE + 32'd12, 8'd0, 32'd1, 1'b0, 0, 0, "rd_after_abort");

        // Reset mid read after three words; memory survives and next begin is served.
        b_begin = 1'b1; b_addr = BASE + 32'd12; b_rnw = 1'b1; b_burst = 8'd7;
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        chk("mrst_w1", o_data, 32'd1);
        @(negedge clock);
        chk("mrst_w2", o_data, 32'd2);
        @(negedge clock);
        chk("mrst_w3", o_data, 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("mrst_dv", 32'(o_dv), 32'd0);
        chk("mrst_data", o_data, 32'h0);
        chk("mrst_end", 32'(o_end), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        read_txn(BASE + 32'd12, 8'd7, 32'd1, 1'b0, 0, 0, "rd_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_burst_responder.md
BUS_BURST_RESPONDER -- requirements
Module: bus_burst_responder

Interface
REQ-001 Parameters: BASE_ADDRESS, 32'h0000_0000, byte address of word 0; DEPTH_WORDS, 1024, 32-bit words stored (power of two); READ_LATENCY, 2, cycles from begin to first read word (1..15); BUSY_PERIOD, 0, on writes assert busy one cycle after every BUSY_PERIOD accepted words (0 = never).
REQ-002 clock  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 busIn_begin_transaction  input  1  one-cycle request strobe from master.
REQ-005 busIn_address_data  input  32  byte address with begin; write data with data_valid.
REQ-006 busIn_read_n_write  input  1  1 = read burst, 0 = write burst; sampled with begin.
REQ-007 busIn_burst_size  input  8  words in burst minus one; sampled with begin.
REQ-008 busIn_data_valid  input  1  master write word valid.
REQ-009 busIn_end_transaction  input  1  master ends write burst.
REQ-010 busIn_busy  input  1  master stalls read delivery.
REQ-011 busIn_error  input  1  master aborts current burst.
REQ-012 busOut_address_data  output  32  read data, zero when data_valid low.
REQ-013 busOut_data_valid  output  1  read word valid.
REQ-014 busOut_end_transaction  output  1  one-cycle end of read burst.
REQ-015 busOut_busy  output  1  write stall to master.
REQ-016 busOut_error  output  1  one-cycle error response.

Function
REQ-017 States SHALL be IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, ERR.
REQ-018 IDLE: begin SHALL latch word index ((address-BASE_ADDRESS)>>2) and count = burst_size; other inputs ignored in IDLE.
REQ-019 Address below BASE_ADDRESS, unaligned (bits[1:0]≠0), or index+burst_size ≥ DEPTH_WORDS SHALL go to ERR; no memory access, no wrap-around.
REQ-020 ERR: busOut_error high exactly one cycle, no end_transaction, then IDLE.
REQ-021 Read: RD_WAIT SHALL last so first busOut_data_valid is READ_LATENCY cycles after begin cycle.
REQ-022 RD_DATA: one word per cycle at consecutive indices; while busIn_busy high, data_valid low and index/count held; exactly burst_size+1 valid words.
REQ-023 RD_END: busOut_end_transaction high one cycle after last valid word, then IDLE.
REQ-024 Write: WR_DATA SHALL store busIn_address_data at current index on each busIn_data_valid cycle with busOut_busy low, then increment index.
REQ-025 data_valid while busOut_busy high SHALL be ignored (master must hold word).
REQ-026 Words beyond burst_size+1 SHALL be discarded; busIn_end_transaction SHALL return to IDLE regardless of count.
REQ-027 busIn_error in any non-IDLE state SHALL return to IDLE next cycle; written words retained, outputs low.
REQ-028 busIn_end_transaction and data_valid in same cycle: word stored, then IDLE.
REQ-029 Memory contents SHALL not be initialised or cleared by reset.

Reset
REQ-030 Reset SHALL force IDLE, counters zero, and all outputs 0 immediately (asynchronous), including mid-burst.
REQ-031 First begin SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-032 State encoding and bus field widths (burst 8, address 32) SHALL live in shared package bus_pkg.
REQ-033 Storage SHALL be one sub-module, responder_sram (sync write, sync read, one port), inferable as block RAM.

Verification
REQ-034 Write 8 words (burst_size 7) to BASE+12, data 1..8 -> words 3..10 hold 1..8, no error.
REQ-035 Read burst_size 7 from BASE+12, READ_LATENCY 2 -> data_valid on cycles 2..9 after begin with 1..8, end_transaction on cycle 10.
REQ-036 Same read with busIn_busy high 2 cycles after 4th word -> same 8 words, end_transaction on cycle 12.
REQ-037 Begin at BASE+4*1020 with burst_size 7 -> busOut_error one cycle, memory unchanged.
REQ-038 Write with BUSY_PERIOD 4, master holding word during busy -> all 8 words stored exactly once.
REQ-039 Reset during RD_DATA after 3 words -> outputs 0 same cycle, next begin serviced normally.
